// File: rtl/ip_tile_alu_pkg.sv
// Shared types and register-packing helpers for the ALU tile command path.
package ip_tile_alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        MUL  = 4'd2,
        DIV  = 4'd3,
        AND  = 4'd4,
        OR   = 4'd5,
        NOT  = 4'd6,
        XOR  = 4'd7,
        XNOR = 4'd8,
        SHL  = 4'd9,
        SHR  = 4'd10,
        INC  = 4'd11,
        DEC  = 4'd12,
        ISUB = 4'd13,
        ASRA = 4'd14,
        ASRB = 4'd15
    } alu_op_e;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int OPERAND_W  = 8;
    localparam int ALU_REG_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    // Register A carries the opcode in the top nibble and operand A in the low byte.
    function automatic logic [ALU_REG_W-1:0] pack_reg_a(input logic [3:0]           op,
                                                        input logic [OPERAND_W-1:0] a);
        logic [ALU_REG_W-1:0] r;
        r = '0;
        r[OPCODE_MSB:OPCODE_LSB] = op;
        r[OPERAND_W-1:0]         = a;
        return r;
    endfunction

    // Register B carries only operand B in the low byte.
    function automatic logic [ALU_REG_W-1:0] pack_reg_b(input logic [OPERAND_W-1:0] b);
        logic [ALU_REG_W-1:0] r;
        r = '0;
        r[OPERAND_W-1:0] = b;
        return r;
    endfunction

endpackage

// File: rtl/ip_tile_alu_cmd_fifo.sv
// Small synchronous FIFO holding packed {opcode, a, b, tag} commands.
module ip_tile_alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Flags come from registered occupancy only, so a pop never frees a slot for a same-cycle push.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset empties the FIFO and clears stored entries.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ip_tile_alu_cmd_sequencer.sv
// Command sequencer feeding ip_tile_alu_8bit_16op: buffers commands, issues one at a
// time into data_reg_a/b, waits the ALU latency, and returns data_reg_c with its tag.
module ip_tile_alu_cmd_sequencer
    import ip_tile_alu_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 1,
    parameter int TAG_WIDTH   = 4,
    parameter int REG_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_opcode,
    input  logic [7:0]           cmd_a,
    input  logic [7:0]           cmd_b,
    input  logic [TAG_WIDTH-1:0] cmd_tag,
    output logic [REG_WIDTH-1:0] data_reg_a,
    output logic [REG_WIDTH-1:0] data_reg_b,
    input  logic [REG_WIDTH-1:0] data_reg_c,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [REG_WIDTH-1:0] res_data,
    output logic [TAG_WIDTH-1:0] res_tag,
    output logic                 busy,
    output logic [7:0]           issued_count
);

    localparam int ENTRY_W = 4 + 2 * OPERAND_W + TAG_WIDTH;
    localparam int CNT_W   = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

    logic [ENTRY_W-1:0]   fifo_din;
    logic [ENTRY_W-1:0]   fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;

    logic [3:0]           head_op;
    logic [7:0]           head_a;
    logic [7:0]           head_b;
    logic [TAG_WIDTH-1:0] head_tag;

    seq_state_e           state_q, state_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [REG_WIDTH-1:0] data_reg_a_q, data_reg_a_d;
    logic [REG_WIDTH-1:0] data_reg_b_q, data_reg_b_d;
    logic                 res_valid_q, res_valid_d;
    logic [REG_WIDTH-1:0] res_data_q, res_data_d;
    logic [TAG_WIDTH-1:0] res_tag_q, res_tag_d;
    logic [7:0]           issued_count_q, issued_count_d;

    // cmd_ready is forced low while reset is asserted so nothing is taken during reset.
    assign cmd_ready = arst_n && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_din  = {cmd_opcode, cmd_a, cmd_b, cmd_tag};

    assign head_op  = fifo_dout[ENTRY_W-1 -: 4];
    assign head_a   = fifo_dout[TAG_WIDTH + OPERAND_W +: OPERAND_W];
    assign head_b   = fifo_dout[TAG_WIDTH +: OPERAND_W];
    assign head_tag = fifo_dout[TAG_WIDTH-1:0];

    ip_tile_alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_cmd_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .push   (fifo_push),
        .din    (fifo_din),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Sequencer next-state: issue from IDLE, count down the ALU latency, hold the result until taken.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        data_reg_a_d   = data_reg_a_q;
        data_reg_b_d   = data_reg_b_q;
        res_valid_d    = res_valid_q;
        res_data_d     = res_data_q;
        res_tag_d      = res_tag_q;
        issued_count_d = issued_count_q;
        fifo_pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop       = 1'b1;
                    data_reg_a_d   = REG_WIDTH'(pack_reg_a(head_op, head_a));
                    data_reg_b_d   = REG_WIDTH'(pack_reg_b(head_b));
                    res_tag_d      = head_tag;
                    wait_cnt_d     = CNT_W'(ALU_LATENCY);
                    issued_count_d = issued_count_q + 8'd1;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    res_data_d  = data_reg_c;
                    res_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered sequencer state and outputs; reset drops any in-flight command.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            data_reg_a_q   <= '0;
            data_reg_b_q   <= '0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            res_tag_q      <= '0;
            issued_count_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            data_reg_a_q   <= data_reg_a_d;
            data_reg_b_q   <= data_reg_b_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
            res_tag_q      <= res_tag_d;
            issued_count_q <= issued_count_d;
        end
    end

    assign data_reg_a   = data_reg_a_q;
    assign data_reg_b   = data_reg_b_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_tag      = res_tag_q;
    assign issued_count = issued_count_q;
    assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ip_tile_alu_cmd_sequencer.sv
// Directed bench for ip_tile_alu_cmd_sequencer with a latency-1 ALU model and a result scoreboard.
module tb_ip_tile_alu_cmd_sequencer;
    import ip_tile_alu_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [3:0]  cmd_tag;
    logic [31:0] data_reg_a;
    logic [31:0] data_reg_b;
    logic [31:0] data_reg_c;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic        busy;
    logic [7:0]  issued_count;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pushed = 0;
    logic [31:0] alu_c_q = '0;

    ip_tile_alu_cmd_sequencer #(
        .FIFO_DEPTH  (4),
        .ALU_LATENCY (1),
        .TAG_WIDTH   (4),
        .REG_WIDTH   (32)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_tag      (cmd_tag),
        .data_reg_a   (data_reg_a),
        .data_reg_b   (data_reg_b),
        .data_reg_c   (data_reg_c),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_tag      (res_tag),
        .busy         (busy),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    // Reference ALU behaviour; division by zero returns a distinctive full-width pattern.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r8;
        r8 = 8'd0;
        case (op)
            ADD:  return {24'd0, a} + {24'd0, b};
            SUB:  r8 = a - b;
            MUL:  return {16'd0, {8'd0, a} * {8'd0, b}};
            DIV:  begin
                if (b == 8'd0) return 32'hDEAD_00FF;
                r8 = a / b;
            end
            AND:  r8 = a & b;
            OR:   r8 = a | b;
            NOT:  r8 = ~a;
            XOR:  r8 = a ^ b;
            XNOR: r8 = ~(a ^ b);
            SHL:  r8 = a << 1;
            SHR:  r8 = a >> 1;
            INC:  r8 = a + 8'd1;
            DEC:  r8 = a - 8'd1;
            ISUB: r8 = b - a;
            ASRA: r8 = $signed(a) >>> 1;
            ASRB: r8 = $signed(b) >>> 1;
            default: r8 = 8'd0;
        endcase
        return {24'd0, r8};
    endfunction

    // Downstream ALU stand-in: one register stage from data_reg_a/b to data_reg_c.
    always @(posedge clk) begin
        alu_c_q <= alu_f(data_reg_a[31:28], data_reg_a[7:0], data_reg_b[7:0]);
    end
    assign data_reg_c = alu_c_q;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $error("FAIL %s observed=timeout expected=event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result monitor: pops the scoreboard on each result handshake.
    always @(negedge clk) begin
        if (arst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL res_unexpected observed tag=%0d data=0x%08h expected no result", res_tag, res_data);
            end else begin
                mon_e = sb.pop_front();
                chk("res_data", res_data, mon_e.data);
                chk("res_tag", {28'd0, res_tag}, {28'd0, mon_e.tag});
            end
        end
    end

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
        int n;
        n = 0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_tag    = tag;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (cmd_ready) begin
            sb.push_back('{alu_f(op, a, b), tag});
            n_pushed++;
            tick();
        end else begin
            timeout("push_wait");
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || res_valid) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) timeout("drain");
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        tick();
        chk("rst_reg_a", data_reg_a, 32'd0);
        chk("rst_reg_b", data_reg_b, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_tag", {28'd0, res_tag}, 32'd0);
        chk("rst_issued", {24'd0, issued_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        sb.delete();
        n_pushed = 0;
        arst_n = 1'b1;
        #1;
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] a_r;
        arst_n     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = 4'd0;
        cmd_a      = 8'd0;
        cmd_b      = 8'd0;
        cmd_tag    = 4'd0;
        res_ready  = 1'b0;
        tick();
        do_reset();

        // 1: single ADD with exact latency
        push(ADD, 8'd10, 8'd5, 4'd1);
        tick();
        chk("t1_reg_a", data_reg_a, 32'h0000_000A);
        chk("t1_reg_b", data_reg_b, 32'h0000_0005);
        chk("t1_issued", {24'd0, issued_count}, 32'd1);
        chk("t1_valid_e1", {31'd0, res_valid}, 32'd0);
        tick();
        chk("t1_valid_e2", {31'd0, res_valid}, 32'd0);
        tick();
        chk("t1_valid_e3", {31'd0, res_valid}, 32'd1);
        chk("t1_res_data", res_data, 32'd15);
        chk("t1_res_tag", {28'd0, res_tag}, 32'd1);
        res_ready = 1'b1;
        drain();

        // 2: back-pressure fills the FIFO, then results drain in order
        res_ready = 1'b0;
        push(ADD, 8'd3, 8'd4, 4'd0);
        push(SUB, 8'd20, 8'd8, 4'd1);
        push(MUL, 8'd7, 8'd6, 4'd2);
        push(XOR, 8'hF0, 8'h3C, 4'd3);
        push(SHL, 8'h81, 8'd0, 4'd4);
        cmd_valid  = 1'b1;
        cmd_opcode = ASRB;
        cmd_a      = 8'h11;
        cmd_b      = 8'h90;
        cmd_tag    = 4'd5;
        tick();
        tick();
        tick();
        chk("t2_cmd_ready_full", {31'd0, cmd_ready}, 32'd0);
        chk("t2_head_valid", {31'd0, res_valid}, 32'd1);
        chk("t2_head_tag", {28'd0, res_tag}, 32'd0);
        res_ready = 1'b1;
        push(ASRB, 8'h11, 8'h90, 4'd5);
        drain();
        chk("t2_issued", {24'd0, issued_count}, 32'(n_pushed[7:0]));

        // 3: divide by zero passes straight through
        res_ready = 1'b0;
        push(DIV, 8'd15, 8'd0, 4'd6);
        tick();
        chk("t3_reg_a", data_reg_a, 32'h3000_000F);
        chk("t3_reg_b", data_reg_b, 32'h0000_0000);
        res_ready = 1'b1;
        drain();
        chk("t3_idle", {31'd0, busy}, 32'd0);

        // 4: result held stable while not consumed
        res_ready = 1'b0;
        push(AND, 8'h5A, 8'h0F, 4'd3);
        push(OR, 8'h01, 8'h02, 4'd9);
        begin
            int n;
            n = 0;
            while (!res_valid && n < 20) begin
                tick();
                n++;
            end
            if (!res_valid) timeout("t4_res_valid");
        end
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", {31'd0, res_valid}, 32'd1);
            chk("t4_hold_data", res_data, 32'h0000_000A);
            chk("t4_hold_tag", {28'd0, res_tag}, 32'd3);
            chk("t4_hold_reg_a", data_reg_a, 32'h4000_005A);
            chk("t4_hold_reg_b", data_reg_b, 32'h0000_000F);
            chk("t4_hold_issued", {24'd0, issued_count}, 32'((n_pushed - 1) & 255));
            chk("t4_hold_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        res_ready = 1'b1;
        drain();

        // 5: reset while a command is in WAIT with two more queued
        push(ADD, 8'd1, 8'd1, 4'd7);
        push(SUB, 8'd9, 8'd2, 4'd8);
        push(MUL, 8'd3, 8'd3, 4'd10);
        chk("t5_in_wait_valid", {31'd0, res_valid}, 32'd0);
        chk("t5_in_wait_busy", {31'd0, busy}, 32'd1);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk("t5_no_result", {31'd0, res_valid}, 32'd0);
            chk("t5_fifo_empty", {31'd0, busy}, 32'd0);
            tick();
        end
        push(XNOR, 8'hA5, 8'h0F, 4'd11);
        drain();
        chk("t5_issued", {24'd0, issued_count}, 32'd1);

        // 6: issued_count wraps at 256
        do_reset();
        for (int i = 0; i < 256; i++) begin
            a_r = (i == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            push(INC, a_r, 8'd0, 4'(i));
        end
        drain();
        chk("t6_wrap_256", {24'd0, issued_count}, 32'd0);
        push(INC, 8'd41, 8'd0, 4'd2);
        drain();
        chk("t6_wrap_257", {24'd0, issued_count}, 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
